fp_add_ctrl: RTL and testbench
==============================

Name: fp_add_ctrl

Overview:
- Control FSM for the floating-point adder datapath; sequences operand load, exponent alignment, mantissa add and normalization.
- Drives the 8-bit exponent up/down counter (ld_exp, cen_up_exp, cen_down_exp) and the mantissa shift/load strobes.
- Consumes comparator/status flags from the datapath and returns done plus overflow/underflow/zero flags to the top level.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; bounds the alignment shift count.
- ACNT_W, 5, width of the internal alignment shift counter; must satisfy 2**ACNT_W > MANT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- a_exp_gt_b  input  1  operand A exponent > operand B exponent (valid from SETUP onward).
- exp_eq  input  1  exponent counter equals larger operand exponent.
- sum_cout  input  1  mantissa sum carry-out.
- sum_msb  input  1  sum hidden-bit position set.
- sum_zero  input  1  mantissa sum is zero.
- exp_max  input  1  exponent counter == 8'hFE.
- exp_min  input  1  exponent counter == 8'h01.
- ld_ops  output  1  load operand registers A and B.
- ld_exp  output  1  parallel-load exponent counter.
- exp_sel  output  2  exponent load source: 0 = exp A, 1 = exp B, 2 = larger exponent.
- cen_up_exp  output  1  increment exponent counter.
- cen_down_exp  output  1  decrement exponent counter.
- swap  output  1  registered: 1 = B is the larger operand (A is shifted).
- sh_small  output  1  shift the smaller mantissa right by 1.
- clr_small  output  1  clear the smaller mantissa.
- ld_sum  output  1  load sum register.
- sh_r_sum  output  1  shift sum right by 1.
- sh_l_sum  output  1  shift sum left by 1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  registered overflow flag.
- unf  output  1  registered underflow flag.
- zero_res  output  1  registered zero-result flag.

Behaviour:
- State register, control strobes decoded combinationally from state plus status inputs, flags registered.
- Reset when rst == 0 at a clock edge: state IDLE, swap = 0, ovf = 0, unf = 0, zero_res = 0, acnt = 0, all strobes and done = 0.
- Reset mid-operation: FSM returns to IDLE at the next edge; no done pulse.
- ld_exp, cen_up_exp and cen_down_exp are mutually exclusive in every cycle.
- IDLE: if start, clear flags and go to LOAD. start is ignored while busy.
- LOAD: ld_ops = 1; next state SETUP.
- SETUP: ld_exp = 1, exp_sel = a_exp_gt_b ? 1 : 0 (load the smaller exponent); swap <= ~a_exp_gt_b; acnt <= 0; next state ALIGN.
- ALIGN, exp_eq = 1: go to ADD.
- ALIGN, exp_eq = 0: cen_up_exp = 1, sh_small = 1, acnt++; stay in ALIGN.
- ADD: ld_sum = 1; next state NORM.
- NORM, priority order:
  1. sum_zero: zero_res <= 1, go to DONE.
  2. sum_cout & exp_max: ovf <= 1, go to DONE.
  3. sum_cout: sh_r_sum = 1, cen_up_exp = 1; stay in NORM.
  4. ~sum_msb & exp_min: unf <= 1, go to DONE.
  5. ~sum_msb: sh_l_sum = 1, cen_down_exp = 1; stay in NORM.
  6. Otherwise: go to DONE.
- DONE: done = 1 for one cycle; go to IDLE. Flags hold until the next accepted start.
- Latency: start sampled at edge k gives done high in the cycle after edge k+5 (minimum 6 cycles). Each alignment shift adds 1 cycle; each normalize shift adds 1 cycle.

Optional Feature:
- Macro: FPC_ALIGN_LIMIT_EN.
- Defined: in ALIGN, if acnt == MANT_W and exp_eq == 0, assert clr_small = 1, ld_exp = 1, exp_sel = 2, then go to ADD. ALIGN is bounded to MANT_W+1 cycles.
- Undefined: ALIGN runs until exp_eq (up to 254 cycles). acnt is still maintained but never used for state transitions.

Test Plan:
- rst = 0 for 2 cycles with start = 1 -> state IDLE, busy = 0, done = 0, flags 0, all strobes 0.
- Equal exponents (exp_eq = 1 at ALIGN), sum_msb = 1 -> done exactly 6 cycles after start, zero cen_up/cen_down pulses, swap = 0 when a_exp_gt_b = 1.
- Exponent difference 3 (exp_eq rises after 3 increments), then sum_cout = 1 once -> 3 sh_small + cen_up_exp pulses, 1 sh_r_sum, done at cycle 10.
- Sum needing 2 left shifts, then exp_min asserted on the 3rd -> 2 sh_l_sum + cen_down_exp pulses, then unf = 1, done.
- sum_cout = 1 with exp_max = 1 -> ovf = 1, no cen_up_exp, done next cycle. Separately, sum_zero = 1 -> zero_res = 1.
- With FPC_ALIGN_LIMIT_EN, exp_eq held 0 -> exactly 24 sh_small pulses, then clr_small + ld_exp with exp_sel = 2. Separately, rst = 0 mid-ALIGN -> IDLE, no done.

Source files
------------

// File: rtl/fp_add_ctrl.sv
// Control FSM for the floating-point adder: operand load, exponent alignment, mantissa add, normalize.
// Optional build macro FPC_ALIGN_LIMIT_EN caps alignment at MANT_W shifts before clearing the small operand.
module fp_add_ctrl #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned ACNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a_exp_gt_b,
    input  logic       exp_eq,
    input  logic       sum_cout,
    input  logic       sum_msb,
    input  logic       sum_zero,
    input  logic       exp_max,
    input  logic       exp_min,
    output logic       ld_ops,
    output logic       ld_exp,
    output logic [1:0] exp_sel,
    output logic       cen_up_exp,
    output logic       cen_down_exp,
    output logic       swap,
    output logic       sh_small,
    output logic       clr_small,
    output logic       ld_sum,
    output logic       sh_r_sum,
    output logic       sh_l_sum,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       unf,
    output logic       zero_res
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSetup,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

    localparam logic [1:0] SelExpA   = 2'd0;
    localparam logic [1:0] SelExpB   = 2'd1;
    localparam logic [1:0] SelExpMax = 2'd2;

    // Shift count at which the smaller mantissa has been shifted out entirely.
    localparam logic [ACNT_W-1:0] AlignLimit = ACNT_W'(MANT_W);

    state_e            state_q, state_d;
    logic              swap_q, swap_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              zero_q, zero_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic [ACNT_W-1:0] acnt_inc;

    // Saturates at the limit so very long alignments cannot wrap the count.
    assign acnt_inc = (acnt_q == AlignLimit) ? acnt_q : acnt_q + ACNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            swap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            swap_q  <= swap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
            acnt_q  <= acnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        swap_d       = swap_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        zero_d       = zero_q;
        acnt_d       = acnt_q;
        ld_ops       = 1'b0;
        ld_exp       = 1'b0;
        exp_sel      = SelExpA;
        cen_up_exp   = 1'b0;
        cen_down_exp = 1'b0;
        sh_small     = 1'b0;
        clr_small    = 1'b0;
        ld_sum       = 1'b0;
        sh_r_sum     = 1'b0;
        sh_l_sum     = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ld_ops  = 1'b1;
                state_d = StSetup;
            end
            StSetup: begin
                // Start the counter at the smaller exponent and count it up to the larger.
                ld_exp  = 1'b1;
                exp_sel = a_exp_gt_b ? SelExpB : SelExpA;
                swap_d  = ~a_exp_gt_b;
                acnt_d  = '0;
                state_d = StAlign;
            end
            StAlign: begin
                if (exp_eq) begin
                    state_d = StAdd;
`ifdef FPC_ALIGN_LIMIT_EN
                end else if (acnt_q == AlignLimit) begin
                    clr_small = 1'b1;
                    ld_exp    = 1'b1;
                    exp_sel   = SelExpMax;
                    state_d   = StAdd;
`endif
                end else begin
                    cen_up_exp = 1'b1;
                    sh_small   = 1'b1;
                    acnt_d     = acnt_inc;
                end
            end
            StAdd: begin
                ld_sum  = 1'b1;
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_zero) begin
                    zero_d  = 1'b1;
                    state_d = StDone;
                end else if (sum_cout && exp_max) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else if (sum_cout) begin
                    sh_r_sum   = 1'b1;
                    cen_up_exp = 1'b1;
                end else if (!sum_msb && exp_min) begin
                    unf_d   = 1'b1;
                    state_d = StDone;
                end else if (!sum_msb) begin
                    sh_l_sum     = 1'b1;
                    cen_down_exp = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign swap     = swap_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign zero_res = zero_q;

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Table-driven bench for fp_add_ctrl with a reactive model of the datapath status flags.
// Builds with or without FPC_ALIGN_LIMIT_EN; the long-alignment vector adapts to the build.
module tb_fp_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a_exp_gt_b;
    logic       exp_eq;
    logic       sum_cout;
    logic       sum_msb;
    logic       sum_zero;
    logic       exp_max;
    logic       exp_min;
    logic       ld_ops;
    logic       ld_exp;
    logic [1:0] exp_sel;
    logic       cen_up_exp;
    logic       cen_down_exp;
    logic       swap;
    logic       sh_small;
    logic       clr_small;
    logic       ld_sum;
    logic       sh_r_sum;
    logic       sh_l_sum;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       unf;
    logic       zero_res;

    always #5 clk = ~clk;

    fp_add_ctrl #(
        .MANT_W(24),
        .ACNT_W(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_exp_gt_b  (a_exp_gt_b),
        .exp_eq      (exp_eq),
        .sum_cout    (sum_cout),
        .sum_msb     (sum_msb),
        .sum_zero    (sum_zero),
        .exp_max     (exp_max),
        .exp_min     (exp_min),
        .ld_ops      (ld_ops),
        .ld_exp      (ld_exp),
        .exp_sel     (exp_sel),
        .cen_up_exp  (cen_up_exp),
        .cen_down_exp(cen_down_exp),
        .swap        (swap),
        .sh_small    (sh_small),
        .clr_small   (clr_small),
        .ld_sum      (ld_sum),
        .sh_r_sum    (sh_r_sum),
        .sh_l_sum    (sh_l_sum),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .unf         (unf),
        .zero_res    (zero_res)
    );

    // mode: 0 msb set, 1 n carries, 2 n left shifts then exp_min, 3 carry at exp_max,
    //       4 zero sum, 5 n left shifts then msb set
    typedef struct {
        logic agtb;
        int   align_n;
        int   mode;
        int   n;
        logic keep_start;
        int   lat;
        int   up;
        int   dn;
        int   shr;
        int   shl;
        int   shs;
        int   clr;
        logic swap;
        logic ovf;
        logic unf;
        logic zero;
        int   sel;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    int checks = 0;
    int errors = 0;

    int   cur_align, cur_mode, cur_n;
    logic cur_agtb;
    int   align_cnt, r_cnt, l_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath model: status flags follow the strobe counts seen in earlier cycles.
    task automatic drive_status();
        a_exp_gt_b = cur_agtb;
        exp_eq     = (align_cnt >= cur_align);
        sum_cout   = (cur_mode == 1 && r_cnt < cur_n) || (cur_mode == 3);
        exp_max    = (cur_mode == 3);
        sum_zero   = (cur_mode == 4);
        sum_msb    = !((cur_mode == 2) || (cur_mode == 5 && l_cnt < cur_n));
        exp_min    = (cur_mode == 2) && (l_cnt >= cur_n);
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int lat, up, dn, shr, shl, shs, clr, nld, excl_bad, clr_bad, sel_first;
        string tag;
        tag = $sformatf("v%0d", idx);
        cur_agtb = v.agtb; cur_align = v.align_n; cur_mode = v.mode; cur_n = v.n;
        align_cnt = 0; r_cnt = 0; l_cnt = 0;
        lat = -1; up = 0; dn = 0; shr = 0; shl = 0; shs = 0; clr = 0; nld = 0;
        excl_bad = 0; clr_bad = 0; sel_first = -1;
        @(posedge clk); #1;
        start = 1'b1;
        drive_status();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            if (ld_exp && sel_first < 0) sel_first = int'(exp_sel);
            if (clr_small) begin
                clr++;
                if (!(ld_exp && exp_sel == 2'd2)) clr_bad++;
            end
            if (int'(ld_exp) + int'(cen_up_exp) + int'(cen_down_exp) > 1) excl_bad++;
            up  += int'(cen_up_exp);
            dn  += int'(cen_down_exp);
            shr += int'(sh_r_sum);
            shl += int'(sh_l_sum);
            shs += int'(sh_small);
            nld += int'(ld_ops);
            if (sh_small) align_cnt++;
            if (sh_r_sum) r_cnt++;
            if (sh_l_sum) l_cnt++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            if (!v.keep_start) start = 1'b0;
            drive_status();
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_cen_up"}, 32'(up), 32'(v.up));
        check({tag, "_cen_down"}, 32'(dn), 32'(v.dn));
        check({tag, "_sh_r_sum"}, 32'(shr), 32'(v.shr));
        check({tag, "_sh_l_sum"}, 32'(shl), 32'(v.shl));
        check({tag, "_sh_small"}, 32'(shs), 32'(v.shs));
        check({tag, "_clr_small"}, 32'(clr), 32'(v.clr));
        check({tag, "_clr_ldexp_sel2"}, 32'(clr_bad), 32'd0);
        check({tag, "_ld_ops"}, 32'(nld), 32'd1);
        check({tag, "_exp_sel_setup"}, 32'(sel_first), 32'(v.sel));
        check({tag, "_exclusive"}, 32'(excl_bad), 32'd0);
        check({tag, "_swap"}, 32'(swap), 32'(v.swap));
        check({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
        check({tag, "_unf"}, 32'(unf), 32'(v.unf));
        check({tag, "_zero_res"}, 32'(zero_res), 32'(v.zero));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_flags_hold"}, {29'd0, ovf, unf, zero_res}, {29'd0, v.ovf, v.unf, v.zero});
    endtask

    initial begin
        int done_seen;
        vec_t v;
        //           agtb align mode n keep  lat up dn shr shl shs clr swap ovf unf zero sel
        vecs[0] = '{1'b1, 0, 0, 0, 1'b0,  6, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 3, 1, 1, 1'b1, 10, 4, 0, 1, 0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 0, 2, 2, 1'b0,  8, 0, 2, 0, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 1, 3, 0, 1'b0,  7, 1, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 2, 4, 0, 1'b0,  8, 2, 0, 0, 0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[5] = '{1'b1, 0, 5, 3, 1'b0,  9, 0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6] = '{1'b0, 5, 1, 2, 1'b0, 13, 7, 0, 2, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
`ifdef FPC_ALIGN_LIMIT_EN
        vecs[7] = '{1'b0, 1000, 0, 0, 1'b0, 30, 24, 0, 0, 0, 24, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
`else
        vecs[7] = '{1'b0, 30, 0, 0, 1'b0, 36, 30, 0, 0, 0, 30, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
`endif

        // Reset held for two edges with start asserted.
        rst = 1'b0; start = 1'b1;
        cur_agtb = 1'b1; cur_align = 0; cur_mode = 0; cur_n = 0;
        align_cnt = 0; r_cnt = 0; l_cnt = 0;
        drive_status();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", {28'd0, swap, ovf, unf, zero_res}, 32'd0);
        check("rst_strobes",
              {21'd0, ld_ops, ld_exp, exp_sel, cen_up_exp, cen_down_exp, sh_small, clr_small,
               ld_sum, sh_r_sum, sh_l_sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            run_op(i, v);
        end

        // Reset while stuck in ALIGN: back to IDLE, never a done pulse.
        cur_agtb = 1'b1; cur_align = 100; cur_mode = 0; cur_n = 0;
        align_cnt = 0; r_cnt = 0; l_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        drive_status();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_align_sh_small", 32'(sh_small), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_align_busy_before_edge", 32'(busy), 32'd1);
        @(negedge clk);
        check("mid_align_rst_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("mid_align_no_done", 32'(done_seen), 32'd0);

        v = vecs[0];
        run_op(8, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
